// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and constants for the PC sequencer
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      PC_FETCH  = 2'd0,
      PC_EXEC   = 2'd1,
      PC_HALTED = 2'd2
   } pc_state_e;

   localparam int HALT_CODE_DEFAULT = 10;

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - combinational next-PC target selection (jalr > jal/taken branch > pc+4)
module next_pc_mux #(
   parameter int XLEN = 32
) (
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic            branch,
   input  logic            bcond,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] rel_target;

   assign jalr_sum   = rs1_data + imm;
   assign rel_target = pc + imm;

   // Register-indirect targets drop bit 0; all sums wrap modulo 2^XLEN.
   always_comb begin
      target = pc_plus4;
      if (is_jalr) begin
         target = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (is_jal || (branch && bcond)) begin
         target = rel_target;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, fetch/exec handshake, ecall halt and retire counter
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              HALT_CODE = HALT_CODE_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic            mem_stall,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic            branch,
   input  logic            bcond,
   input  logic            is_ecall,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] x17_data,
   output logic            fetch_req,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            exec_en,
   output logic            commit,
   output logic            is_halted,
   output logic [31:0]     retired_count
);

   pc_state_e       state;
   pc_state_e       next_state;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] target;
   logic            halt_hit;

   assign pc_plus4 = pc + XLEN'(4);
   assign halt_hit = is_ecall && (x17_data == XLEN'(HALT_CODE));

   next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
      .is_jal   (is_jal),
      .is_jalr  (is_jalr),
      .branch   (branch),
      .bcond    (bcond),
      .pc       (pc),
      .pc_plus4 (pc_plus4),
      .imm      (imm),
      .rs1_data (rs1_data),
      .target   (target)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= PC_FETCH;
         pc            <= RESET_PC;
         retired_count <= '0;
      end else begin
         state <= next_state;
         pc    <= pc_next;
         if (commit) begin
            retired_count <= retired_count + 32'd1;
         end
      end
   end

   always_comb begin
      next_state = state;
      pc_next    = pc;
      fetch_req  = 1'b0;
      exec_en    = 1'b0;
      commit     = 1'b0;
      is_halted  = 1'b0;
      case (state)
         PC_FETCH: begin
            fetch_req = 1'b1;
            if (instr_valid) begin
               next_state = PC_EXEC;
            end
         end
         PC_EXEC: begin
            exec_en = 1'b1;
            if (!mem_stall) begin
               // A reset on this edge wins, so the retire pulse is suppressed.
               commit = !reset;
               if (halt_hit) begin
                  next_state = PC_HALTED;
               end else begin
                  next_state = PC_FETCH;
                  pc_next    = target;
               end
            end
         end
         PC_HALTED: begin
            is_halted = 1'b1;
         end
         default: begin
            next_state = PC_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] cnt;
      logic        halted;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        mem_stall;
   logic        is_jal;
   logic        is_jalr;
   logic        branch;
   logic        bcond;
   logic        is_ecall;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic [31:0] x17_data;
   logic        fetch_req;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        exec_en;
   logic        commit;
   logic        is_halted;
   logic [31:0] retired_count;

   int          total;
   int          passed;
   logic [31:0] model_pc;
   logic [31:0] model_count;
   exp_t        sb[$];

   pc_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000), .HALT_CODE(10)) dut (
      .clk           (clk),
      .reset         (reset),
      .instr_valid   (instr_valid),
      .mem_stall     (mem_stall),
      .is_jal        (is_jal),
      .is_jalr       (is_jalr),
      .branch        (branch),
      .bcond         (bcond),
      .is_ecall      (is_ecall),
      .imm           (imm),
      .rs1_data      (rs1_data),
      .x17_data      (x17_data),
      .fetch_req     (fetch_req),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .exec_en       (exec_en),
      .commit        (commit),
      .is_halted     (is_halted),
      .retired_count (retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic clear_ctrl();
      is_jal   = 1'b0;
      is_jalr  = 1'b0;
      branch   = 1'b0;
      bcond    = 1'b0;
      is_ecall = 1'b0;
      imm      = '0;
      rs1_data = '0;
      x17_data = '0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"}, pc, 32'h0);
      check({tag, "_fetch_req"}, {31'b0, fetch_req}, 32'd1);
      check({tag, "_exec_en"}, {31'b0, exec_en}, 32'd0);
      check({tag, "_commit"}, {31'b0, commit}, 32'd0);
      check({tag, "_halted"}, {31'b0, is_halted}, 32'd0);
      check({tag, "_retired"}, retired_count, 32'd0);
   endtask

   // One instruction: optional FETCH wait, optional EXEC stall, then commit.
   task automatic run_instr(input int fwait, input int stall,
                            input logic jal, input logic jalr, input logic br,
                            input logic bc, input logic ec,
                            input logic [31:0] immv, input logic [31:0] rs1v,
                            input logic [31:0] x17v, input logic [31:0] exp_next,
                            input logic halt);
      exp_t e;
      exp_t got;
      check("fetch_req", {31'b0, fetch_req}, 32'd1);
      check("fetch_pc", pc, model_pc);
      for (int i = 0; i < fwait; i++) begin
         @(negedge clk);
         #1;
         check("wait_fetch_req", {31'b0, fetch_req}, 32'd1);
         check("wait_pc", pc, model_pc);
      end
      instr_valid = 1'b1;
      @(negedge clk);
      #1;
      instr_valid = 1'b0;
      is_jal   = jal;
      is_jalr  = jalr;
      branch   = br;
      bcond    = bc;
      is_ecall = ec;
      imm      = immv;
      rs1_data = rs1v;
      x17_data = x17v;
      mem_stall = (stall > 0);
      #1;
      check("exec_en", {31'b0, exec_en}, 32'd1);
      check("pc_plus4", pc_plus4, model_pc + 32'd4);
      for (int i = 0; i < stall; i++) begin
         instr_valid = 1'b1;
         #1;
         check("stall_commit", {31'b0, commit}, 32'd0);
         check("stall_pc", pc, model_pc);
         @(negedge clk);
         #1;
      end
      instr_valid = 1'b0;
      mem_stall = 1'b0;
      #1;
      check("commit", {31'b0, commit}, 32'd1);
      e.pc     = exp_next;
      e.cnt    = model_count + 32'd1;
      e.halted = halt;
      sb.push_back(e);
      model_count = model_count + 32'd1;
      model_pc    = exp_next;
      @(negedge clk);
      #1;
      clear_ctrl();
      check("sb_depth", sb.size(), 32'd1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check("next_pc", pc, got.pc);
         check("retired", retired_count, got.cnt);
         check("halted", {31'b0, is_halted}, {31'b0, got.halted});
         check("post_commit", {31'b0, commit}, 32'd0);
      end
   endtask

   initial begin
      total       = 0;
      passed      = 0;
      model_pc    = 32'h0;
      model_count = 32'h0;
      reset       = 1'b1;
      instr_valid = 1'b0;
      mem_stall   = 1'b0;
      clear_ctrl();
      repeat (2) @(negedge clk);
      #1;
      check_reset_state("rst");
      reset = 1'b0;

      // straight line, JAL, JALR with LSB clear
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'h1, 32'h0, 32'h0, 32'h4, 1'b0);
      run_instr(0, 0, 0, 0, 0, 0, 0, 32'h1, 32'h0, 32'h0, 32'h8, 1'b0);
      run_instr(0, 0, 1, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h18, 1'b0);
      check("retired3", retired_count, 32'd3);
      run_instr(0, 0, 0, 1, 0, 0, 0, 32'h4, 32'h101, 32'h0, 32'h104, 1'b0);
      run_instr(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FF1C, 32'h0, 32'h0, 32'h20, 1'b0);
      // branches not taken / taken backwards
      run_instr(0, 0, 0, 0, 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h24, 1'b0);
      run_instr(0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h1C, 1'b0);
      // all jump controls together: jalr wins
      run_instr(0, 0, 1, 1, 1, 1, 0, 32'h10, 32'h31, 32'h0, 32'h40, 1'b0);
      // fetch wait and exec stall
      run_instr(5, 3, 0, 0, 0, 0, 0, 32'h1, 32'h0, 32'h0, 32'h44, 1'b0);
      // non-halting ecall
      run_instr(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'd5, 32'h48, 1'b0);

      // reset during a stall with a jump pending
      instr_valid = 1'b1;
      @(negedge clk);
      #1;
      instr_valid = 1'b0;
      mem_stall = 1'b1;
      is_jal = 1'b1;
      imm = 32'h100;
      @(negedge clk);
      #1;
      check("midstall_pc", pc, 32'h48);
      reset = 1'b1;
      mem_stall = 1'b0;
      #1;
      check("midstall_rst_commit", {31'b0, commit}, 32'd0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      clear_ctrl();
      check_reset_state("stall_rst");
      model_pc = 32'h0;
      model_count = 32'h0;

      // wrap below zero, wrap back, then halting ecall
      run_instr(0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0);
      run_instr(0, 0, 1, 0, 0, 0, 0, 32'h44, 32'h0, 32'h0, 32'h40, 1'b0);
      run_instr(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'd10, 32'h40, 1'b1);
      for (int i = 0; i < 3; i++) begin
         instr_valid = 1'b1;
         @(negedge clk);
         #1;
         instr_valid = 1'b0;
         check("halt_pc", pc, 32'h40);
         check("halt_flag", {31'b0, is_halted}, 32'd1);
         check("halt_fetch_req", {31'b0, fetch_req}, 32'd0);
         check("halt_exec_en", {31'b0, exec_en}, 32'd0);
         check("halt_commit", {31'b0, commit}, 32'd0);
         check("halt_retired", retired_count, 32'd3);
      end

      // reset while halted
      reset = 1'b1;
      #1;
      check("halt_rst_commit", {31'b0, commit}, 32'd0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      check_reset_state("halt_rst");
      check("sb_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
